load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory stage placed directly downstream of the ALU in the RV32I core.
- Consumes the ALU result as the effective address, with rs2 as store data, and performs LB/LH/LW/LBU/LHU/SB/SH/SW against a variable-latency data memory through a valid/ready request channel and a valid response channel.
- Holds the core with `stall` until the access completes, then presents extended load data or an error for one cycle.

Parameters:
- TIMEOUT_CYCLES, 255: cycles spent in ISSUE+WAIT before the access aborts with an error. Must be ≥2 and ≤65535.

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-low reset
- req_valid  input  1  core presents a load/store this cycle
- req_is_store  input  1  1=store, 0=load
- req_funct3  input  3  RV32I funct3 of the load/store
- req_addr  input  32  effective address (ALU result)
- req_wdata  input  32  store data (rs2)
- stall  output  1  core must hold PC/instruction
- done  output  1  one-cycle completion pulse
- error  output  1  valid with done: misaligned, illegal funct3, or timeout
- load_data  output  32  extended load result, valid with done on loads
- mem_req_valid  output  1  memory request valid
- mem_req_ready  input  1  memory accepts request
- mem_addr  output  32  word address {req_addr[31:2],2'b00}
- mem_we  output  1  write request
- mem_wstrb  output  4  byte enables
- mem_wdata  output  32  lane-replicated store data
- mem_resp_valid  input  1  load response valid
- mem_resp_rdata  input  32  load response word

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, timeout counter=0.
  - All registered outputs are 0: done, error, load_data, mem_req_valid, mem_addr, mem_we, mem_wstrb, mem_wdata.
  - A reset during ISSUE or WAIT drops mem_req_valid immediately. The access is abandoned.
- States and transitions:
  - IDLE:
    - If req_valid=1, capture addr, funct3, is_store, wdata.
    - Aligned and legal: next state is ISSUE.
    - Misaligned or illegal: next state is DONE with error=1 and no memory access.
  - ISSUE:
    - mem_req_valid=1, with addr/we/wstrb/wdata stable.
    - Handshake when mem_req_ready=1. A store goes to DONE; a load goes to WAIT.
  - WAIT:
    - A load leaves on mem_resp_valid=1, capturing the extended data, and goes to DONE.
    - A response in the same cycle as acceptance is not observed. The response must arrive ≥1 cycle after acceptance.
  - DONE:
    - done=1 for exactly one cycle, with error and load_data valid.
    - Always returns to IDLE. A new request is accepted only in IDLE, so the held instruction is never replayed.
- stall = (state==IDLE && req_valid) || state==ISSUE || state==WAIT. stall is 0 in DONE and is combinational.
- Minimum latency, counted from the req_valid cycle (C0) with ready/resp asserted at the earliest legal time:
  - Store: done in C2.
  - Load: done in C3.
  - Error: done in C1.
- Alignment:
  - Halfword requires addr[0]=0.
  - Word requires addr[1:0]=0.
  - Byte accesses are always aligned.
- Legal funct3:
  - Loads: 000, 001, 010, 100, 101.
  - Stores: 000, 001, 010.
  - Anything else is illegal and reported as error.
- Store lanes, with off=addr[1:0]:
  - SB: wstrb=0001<<off, wdata={4{wdata[7:0]}}.
  - SH: wstrb=0011<<off, wdata={2{wdata[15:0]}}.
  - SW: wstrb=1111, wdata unchanged.
  - Loads drive wstrb=0000 and we=0.
- Load extract:
  - Bytes use rdata[8*off+7:8*off]; halfwords use rdata[8*off+15:8*off].
  - LB and LH sign-extend to 32 bits; LBU and LHU zero-extend; LW passes the word through.
  - load_data=0 on stores and on any error.
- Timeout:
  - The counter clears on entry to ISSUE and increments each cycle in ISSUE or WAIT.
  - When it reaches TIMEOUT_CYCLES without the pending handshake or response, the access aborts: go to DONE with error=1 and drop mem_req_valid. This is the only case where valid drops before ready.
- A mem_resp_valid arriving in IDLE, ISSUE or DONE is ignored, including late responses after a timeout.

Test Plan:
- Reset mid-WAIT: drive reset=0 asynchronously → mem_req_valid=0, stall=0 and done=0 with no clock edge; the first request after release completes normally.
- LW: addr=0x100 with ready=1 and resp_rdata=0xDEADBEEF one cycle later → mem_addr=0x100, wstrb=0000; done in C3 with load_data=0xDEADBEEF, error=0; stall=1 for C0–C2 and 0 in C3.
- LB/LBU: addr=0x103 with rdata=0x80FF7F01 → LB gives load_data=0xFFFFFF80; LBU gives 0x00000080. LH at 0x102 gives 0xFFFF80FF.
- SB/SH: SB at addr=0x102 with wdata=0x12345678 → wstrb=0100, mem_wdata=0x78787878, mem_we=1; hold ready=0 for 5 cycles → valid and payload stable, done one cycle after acceptance. SH at 0x102 gives wstrb=1100, wdata=0x56785678.
- Errors: LW at 0x101, or load funct3=011 → no mem_req_valid, done+error in C1, load_data=0. Held-request check: keep req_valid=1 after done → exactly one new access is started from IDLE.
- Timeout: TIMEOUT_CYCLES=8, LW with ready=1 and no response → done+error 8 cycles after ISSUE entry; a response injected 2 cycles later is ignored, with no second done.

Source files
------------

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//
// Memory stage of the RV32I core. It sits directly after the ALU. The ALU
// result is the effective address and rs2 is the store data. The unit runs
// LB/LH/LW/LBU/LHU/SB/SH/SW against a variable-latency data memory and holds
// the core with `stall` until the access completes. It then pulses `done`
// for one cycle, together with `error` and the extended `load_data`.
//
// Parameters:
//   TIMEOUT_CYCLES   cycles allowed in ISSUE+WAIT before an access aborts
//                    with an error. Legal range is 2..65535.
//
// Ports:
//   clk              single clock, rising edge
//   reset            asynchronous, active-low reset
//   req_valid        core presents a load/store this cycle
//   req_is_store     1 = store, 0 = load
//   req_funct3       RV32I funct3 of the access
//   req_addr         effective address (ALU result)
//   req_wdata        store data (rs2)
//   stall            core must hold PC/instruction (combinational)
//   done             one-cycle completion pulse
//   error            valid with done: misaligned, illegal funct3 or timeout
//   load_data        extended load result, valid with done
//   mem_req_valid    memory request valid
//   mem_req_ready    memory accepts the request
//   mem_addr         word address of the access
//   mem_we           write request
//   mem_wstrb        byte enables
//   mem_wdata        lane-replicated store data
//   mem_resp_valid   load response valid
//   mem_resp_rdata   load response word
// ---------------------------------------------------------------------------
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        done,
    output logic        error,
    output logic [31:0] load_data,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_rdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

    state_t      state;
    state_t      next_state;
    logic [15:0] cnt;

    // Captured attributes of the access in flight. The load extractor needs
    // them after the request inputs have moved on.
    logic [2:0]  cap_funct3;
    logic [1:0]  cap_off;
    logic        cap_store;

    logic        f3_legal;
    logic        aligned;
    logic        req_ok;
    logic [3:0]  st_wstrb;
    logic [31:0] st_wdata;
    logic [31:0] shifted;
    logic [31:0] extracted;
    logic        timeout_hit;
    logic        next_error;
    logic [31:0] next_load_data;

    assign stall = ((state == S_IDLE) && req_valid) ||
                   (state == S_ISSUE) || (state == S_WAIT);

    // Request legality. Only funct3[1:0] sets the access size, so alignment
    // is judged from it alone. An illegal funct3 fails f3_legal anyway.
    always_comb begin
        f3_legal = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
            3'b100, 3'b101:         f3_legal = !req_is_store;
            default:                f3_legal = 1'b0;
        endcase
        aligned = 1'b1;
        case (req_funct3[1:0])
            2'b01:   aligned = !req_addr[0];
            2'b10:   aligned = (req_addr[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
    end

    assign req_ok = f3_legal && aligned;

    // Store lane steering. The data is replicated across lanes, so the
    // strobe alone picks which byte(s) memory writes.
    always_comb begin
        st_wstrb = 4'b0000;
        st_wdata = 32'h0;
        if (req_is_store) begin
            case (req_funct3[1:0])
                2'b00: begin
                    st_wstrb = 4'b0001 << req_addr[1:0];
                    st_wdata = {4{req_wdata[7:0]}};
                end
                2'b01: begin
                    st_wstrb = 4'b0011 << req_addr[1:0];
                    st_wdata = {2{req_wdata[15:0]}};
                end
                default: begin
                    st_wstrb = 4'b1111;
                    st_wdata = req_wdata;
                end
            endcase
        end
    end

    // Load extraction. Shift the addressed lane down to bit 0, then sign- or
    // zero-extend it according to the captured funct3.
    assign shifted = mem_resp_rdata >> {cap_off, 3'b000};

    always_comb begin
        case (cap_funct3)
            3'b000:  extracted = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  extracted = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  extracted = {24'h0, shifted[7:0]};
            3'b101:  extracted = {16'h0, shifted[15:0]};
            default: extracted = mem_resp_rdata;
        endcase
    end

    // The abort fires in the last allowed cycle, so the access spends
    // exactly TIMEOUT_CYCLES cycles in ISSUE+WAIT. A handshake or response
    // in that same cycle still wins.
    assign timeout_hit = ((cnt + 16'd1) == TIMEOUT_LIM);

    // State register and timeout counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= 16'd0;
        end else begin
            state <= next_state;
            if (state == S_IDLE)
                cnt <= 16'd0;
            else if ((state == S_ISSUE) || (state == S_WAIT))
                cnt <= cnt + 16'd1;
        end
    end

    // Next-state logic, and the values done/error/load_data take on entering DONE.
    always_comb begin
        next_state     = state;
        next_error     = 1'b0;
        next_load_data = 32'h0;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_ok) begin
                        next_state = S_ISSUE;
                    end else begin
                        next_state = S_DONE;
                        next_error = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (mem_req_ready) begin
                    next_state = cap_store ? S_DONE : S_WAIT;
                end else if (timeout_hit) begin
                    next_state = S_DONE;
                    next_error = 1'b1;
                end
            end
            S_WAIT: begin
                if (mem_resp_valid) begin
                    next_state     = S_DONE;
                    next_load_data = extracted;
                end else if (timeout_hit) begin
                    next_state = S_DONE;
                    next_error = 1'b1;
                end
            end
            S_DONE: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Registered outputs. done/error/load_data last only for the DONE
    // cycle. The memory payload is captured once in IDLE and then held
    // stable for the whole handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done          <= 1'b0;
            error         <= 1'b0;
            load_data     <= 32'h0;
            mem_req_valid <= 1'b0;
            mem_addr      <= 32'h0;
            mem_we        <= 1'b0;
            mem_wstrb     <= 4'b0000;
            mem_wdata     <= 32'h0;
            cap_funct3    <= 3'b000;
            cap_off       <= 2'b00;
            cap_store     <= 1'b0;
        end else begin
            done          <= (next_state == S_DONE);
            error         <= next_error;
            load_data     <= next_load_data;
            mem_req_valid <= (next_state == S_ISSUE);
            if ((state == S_IDLE) && req_valid && req_ok) begin
                mem_addr   <= {req_addr[31:2], 2'b00};
                mem_we     <= req_is_store;
                mem_wstrb  <= st_wstrb;
                mem_wdata  <= st_wdata;
                cap_funct3 <= req_funct3;
                cap_off    <= req_addr[1:0];
                cap_store  <= req_is_store;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
//
// Self-checking bench for load_store_unit. The stimulus process drives
// directed accesses and pushes the expected {error, load_data} of each one
// into a scoreboard queue. A separate monitor pops and compares on every
// done pulse. Cycle-exact checks (latency, stall, memory payload) are made
// inline by the stimulus tasks.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        done;
    logic        error;
    logic [31:0] load_data;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;

    int compared   = 0;
    int mismatched = 0;

    // Expected {error, load_data} for each pending done pulse.
    logic [32:0] sb[$];

    load_store_unit #(.TIMEOUT_CYCLES(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_is_store   (req_is_store),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .stall          (stall),
        .done           (done),
        .error          (error),
        .load_data      (load_data),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_addr       (mem_addr),
        .mem_we         (mem_we),
        .mem_wstrb      (mem_wstrb),
        .mem_wdata      (mem_wdata),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Step to 1 time unit after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (reset && done) begin
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_done: got done=1 error=%b data=%h expected no done",
                         error, load_data);
            end else begin
                logic [32:0] e;
                e = sb.pop_front();
                check_output("sb_error", {31'h0, error}, {31'h0, e[32]});
                check_output("sb_load_data", load_data, e[31:0]);
            end
        end
    end

    task automatic apply_stimulus(input logic st, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] wd);
        req_valid    = 1'b1;
        req_is_store = st;
        req_funct3   = f3;
        req_addr     = addr;
        req_wdata    = wd;
    endtask

    // Load with ready in C1 and response in C2; done is expected in C3.
    task automatic run_load(input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] rdata, input logic [31:0] exp);
        logic [31:0] waddr;
        waddr = {addr[31:2], 2'b00};
        apply_stimulus(1'b0, f3, addr, 32'h0);
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b0;
        sb.push_back({1'b0, exp});
        #1;
        check_output("ld_c0_stall", {31'h0, stall}, 32'h1);
        cyc();
        req_valid = 1'b0;
        check_output("ld_c1_valid", {31'h0, mem_req_valid}, 32'h1);
        check_output("ld_c1_addr", mem_addr, waddr);
        check_output("ld_c1_wstrb", {28'h0, mem_wstrb}, 32'h0);
        check_output("ld_c1_we", {31'h0, mem_we}, 32'h0);
        cyc();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = rdata;
        check_output("ld_c2_stall", {31'h0, stall}, 32'h1);
        check_output("ld_c2_valid", {31'h0, mem_req_valid}, 32'h0);
        cyc();
        mem_resp_valid = 1'b0;
        check_output("ld_c3_done", {31'h0, done}, 32'h1);
        check_output("ld_c3_stall", {31'h0, stall}, 32'h0);
        cyc();
        check_output("ld_c4_done", {31'h0, done}, 32'h0);
    endtask

    // Store with ready held low for `hold` cycles; done one cycle after accept.
    task automatic run_store(input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd, input int hold,
                             input logic [3:0] exp_strb, input logic [31:0] exp_wd);
        logic [31:0] waddr;
        waddr = {addr[31:2], 2'b00};
        apply_stimulus(1'b1, f3, addr, wd);
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        sb.push_back({1'b0, 32'h0});
        cyc();
        req_valid = 1'b0;
        for (int i = 0; i <= hold; i++) begin
            if (i == hold) mem_req_ready = 1'b1;
            check_output("st_valid", {31'h0, mem_req_valid}, 32'h1);
            check_output("st_addr", mem_addr, waddr);
            check_output("st_we", {31'h0, mem_we}, 32'h1);
            check_output("st_wstrb", {28'h0, mem_wstrb}, {28'h0, exp_strb});
            check_output("st_wdata", mem_wdata, exp_wd);
            check_output("st_no_done", {31'h0, done}, 32'h0);
            cyc();
        end
        mem_req_ready = 1'b0;
        check_output("st_done", {31'h0, done}, 32'h1);
        check_output("st_done_stall", {31'h0, stall}, 32'h0);
        check_output("st_done_valid", {31'h0, mem_req_valid}, 32'h0);
        cyc();
        check_output("st_after_done", {31'h0, done}, 32'h0);
    endtask

    // Misaligned or illegal access: done+error in C1, no memory request.
    task automatic run_error(input logic st, input logic [2:0] f3,
                             input logic [31:0] addr);
        apply_stimulus(st, f3, addr, 32'hFFFF_FFFF);
        mem_req_ready = 1'b1;
        sb.push_back({1'b1, 32'h0});
        #1;
        check_output("err_c0_stall", {31'h0, stall}, 32'h1);
        cyc();
        req_valid = 1'b0;
        check_output("err_c1_done", {31'h0, done}, 32'h1);
        check_output("err_c1_valid", {31'h0, mem_req_valid}, 32'h0);
        check_output("err_c1_stall", {31'h0, stall}, 32'h0);
        cyc();
        check_output("err_c2_done", {31'h0, done}, 32'h0);
        check_output("err_c2_valid", {31'h0, mem_req_valid}, 32'h0);
        mem_req_ready = 1'b0;
    endtask

    // Asynchronous reset in the middle of an access, then a normal load.
    task automatic run_reset(input logic in_wait);
        apply_stimulus(1'b0, 3'b010, 32'h0000_0300, 32'h0);
        mem_req_ready  = in_wait;
        mem_resp_valid = 1'b0;
        sb.push_back({1'b0, 32'h0});
        cyc();
        req_valid = 1'b0;
        if (in_wait) begin
            cyc();
            mem_req_ready = 1'b0;
        end
        check_output("rst_pre_stall", {31'h0, stall}, 32'h1);
        #2;
        reset = 1'b0;
        #1;
        check_output("rst_valid", {31'h0, mem_req_valid}, 32'h0);
        check_output("rst_stall", {31'h0, stall}, 32'h0);
        check_output("rst_done", {31'h0, done}, 32'h0);
        sb.delete();
        cyc();
        reset = 1'b1;
        cyc();
        run_load(3'b010, 32'h0000_0304, 32'h0BAD_F00D, 32'h0BAD_F00D);
    endtask

    initial begin
        reset          = 1'b0;
        req_valid      = 1'b0;
        req_is_store   = 1'b0;
        req_funct3     = 3'b000;
        req_addr       = 32'h0;
        req_wdata      = 32'h0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = 32'h0;

        #12;
        check_output("rst_done0", {31'h0, done}, 32'h0);
        check_output("rst_error0", {31'h0, error}, 32'h0);
        check_output("rst_load_data0", load_data, 32'h0);
        check_output("rst_req_valid0", {31'h0, mem_req_valid}, 32'h0);
        check_output("rst_addr0", mem_addr, 32'h0);
        check_output("rst_we0", {31'h0, mem_we}, 32'h0);
        check_output("rst_wstrb0", {28'h0, mem_wstrb}, 32'h0);
        check_output("rst_wdata0", mem_wdata, 32'h0);
        check_output("rst_stall0", {31'h0, stall}, 32'h0);
        reset = 1'b1;
        cyc();

        run_load(3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        run_load(3'b000, 32'h0000_0103, 32'h80FF_7F01, 32'hFFFF_FF80);
        run_load(3'b100, 32'h0000_0103, 32'h80FF_7F01, 32'h0000_0080);
        run_load(3'b001, 32'h0000_0102, 32'h80FF_7F01, 32'hFFFF_80FF);
        run_load(3'b101, 32'h0000_0102, 32'h80FF_7F01, 32'h0000_80FF);
        run_load(3'b000, 32'h0000_0101, 32'h80FF_7F01, 32'h0000_007F);
        run_load(3'b001, 32'h0000_0100, 32'h80FF_7F01, 32'h0000_7F01);

        run_store(3'b000, 32'h0000_0102, 32'h1234_5678, 5, 4'b0100, 32'h7878_7878);
        run_store(3'b001, 32'h0000_0102, 32'h1234_5678, 0, 4'b1100, 32'h5678_5678);
        run_store(3'b010, 32'h0000_0100, 32'hA5A5_0F0F, 1, 4'b1111, 32'hA5A5_0F0F);
        run_store(3'b000, 32'h0000_0101, 32'h1234_5678, 0, 4'b0010, 32'h7878_7878);

        run_error(1'b0, 3'b010, 32'h0000_0101);
        run_error(1'b0, 3'b011, 32'h0000_0100);
        run_error(1'b1, 3'b100, 32'h0000_0100);
        run_error(1'b0, 3'b001, 32'h0000_0103);

        // Held request: the core keeps req_valid high after done and moves
        // on to the next instruction. Exactly one new access must start.
        apply_stimulus(1'b0, 3'b011, 32'h0000_0100, 32'h0);
        sb.push_back({1'b1, 32'h0});
        cyc();
        apply_stimulus(1'b0, 3'b010, 32'h0000_0104, 32'h0);
        sb.push_back({1'b0, 32'hCAFE_F00D});
        check_output("held_c1_done", {31'h0, done}, 32'h1);
        check_output("held_c1_stall", {31'h0, stall}, 32'h0);
        cyc();
        mem_req_ready = 1'b1;
        check_output("held_c2_stall", {31'h0, stall}, 32'h1);
        check_output("held_c2_valid", {31'h0, mem_req_valid}, 32'h0);
        cyc();
        req_valid = 1'b0;
        check_output("held_c3_valid", {31'h0, mem_req_valid}, 32'h1);
        check_output("held_c3_addr", mem_addr, 32'h0000_0104);
        cyc();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'hCAFE_F00D;
        check_output("held_c4_valid", {31'h0, mem_req_valid}, 32'h0);
        cyc();
        mem_resp_valid = 1'b0;
        check_output("held_c5_done", {31'h0, done}, 32'h1);
        cyc();
        check_output("held_c6_done", {31'h0, done}, 32'h0);
        cyc();
        check_output("held_c7_valid", {31'h0, mem_req_valid}, 32'h0);

        // Timeout: accepted load whose response never arrives.
        apply_stimulus(1'b0, 3'b010, 32'h0000_0200, 32'h0);
        mem_req_ready = 1'b1;
        sb.push_back({1'b1, 32'h0});
        cyc();
        req_valid = 1'b0;
        check_output("to_c1_valid", {31'h0, mem_req_valid}, 32'h1);
        cyc();
        mem_req_ready = 1'b0;
        for (int k = 2; k <= 8; k++) begin
            check_output("to_wait_done", {31'h0, done}, 32'h0);
            check_output("to_wait_stall", {31'h0, stall}, 32'h1);
            cyc();
        end
        check_output("to_c9_done", {31'h0, done}, 32'h1);
        check_output("to_c9_error", {31'h0, error}, 32'h1);
        cyc();
        check_output("to_c10_done", {31'h0, done}, 32'h0);
        cyc();
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'h1111_1111;
        cyc();
        mem_resp_valid = 1'b0;
        check_output("to_late_done", {31'h0, done}, 32'h0);
        check_output("to_late_stall", {31'h0, stall}, 32'h0);
        cyc();
        check_output("to_late_done2", {31'h0, done}, 32'h0);

        run_reset(1'b0);
        run_reset(1'b1);

        cyc();
        check_output("sb_drain", sb.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion expected finish before 200000");
        mismatched++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
